// File: rtl/bios_transmitter.sv
// Host-side boot-image sender: takes 32-bit words over valid/ready and shifts each one
// out as four back-to-back 8N1 UART frames, low byte first.
module bios_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid,
  input  logic        last,
  output logic        ready,
  output logic        tx,
  output logic        busy,
  output logic        word_sent,
  output logic        done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [1:0]      byte_q;
  logic [31:0]     word_q;
  logic            last_q;

  logic [7:0]      cur_byte;
  logic            bit_end;

  assign cur_byte = 8'(word_q >> {byte_q, 3'b000});
  assign bit_end  = (cnt_q == CntMax);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      tx        <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
      word_sent <= 1'b0;
      done      <= 1'b0;
    end else begin
      word_sent <= 1'b0;
      done      <= 1'b0;
      // Cycle counter only runs while a word is in flight and restarts at every bit edge.
      if (state_q == StIdle || bit_end) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (valid && ready) begin
            word_q  <= data_in;
            last_q  <= last;
            byte_q  <= '0;
            bit_q   <= '0;
            tx      <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            bit_q   <= '0;
            tx      <= cur_byte[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx    <= cur_byte[bit_q + 3'd1];
            end
          end
        end
        StStop: begin
          if (bit_end) begin
            if (byte_q == 2'd3) begin
              byte_q    <= '0;
              ready     <= 1'b1;
              busy      <= 1'b0;
              word_sent <= 1'b1;
              done      <= last_q;
              state_q   <= StIdle;
            end else begin
              byte_q  <= byte_q + 2'd1;
              tx      <= 1'b0;
              state_q <= StStart;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bios_transmitter.sv
// Directed bench for bios_transmitter at CLKS_PER_BIT=4; every tx sample is checked against
// a frame model built from the word handed to the DUT.
module tb_bios_transmitter;

  localparam int unsigned Cpb = 4;
  localparam int MDrop = 0;
  localparam int MHold = 1;
  localparam int MScramble = 2;

  logic        clock;
  logic        reset;
  logic [31:0] data_in;
  logic        valid;
  logic        last;
  logic        ready;
  logic        tx;
  logic        busy;
  logic        word_sent;
  logic        done;

  int checks = 0;
  int errors = 0;

  bios_transmitter #(.CLKS_PER_BIT(Cpb)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .valid    (valid),
    .last     (last),
    .ready    (ready),
    .tx       (tx),
    .busy     (busy),
    .word_sent(word_sent),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the accepting edge: 10-bit frames, 4 cycles per bit.
  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int slot;
    int b;
    int s;
    slot = k / Cpb;
    b    = slot / 10;
    s    = slot % 10;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return w[b*8 + s - 1];
  endfunction

  // Called at the negedge where valid is presented; returns at the negedge of the word_sent cycle.
  task automatic expect_word(input logic [31:0] w, input logic l, input int mode);
    for (int k = 0; k < 40 * Cpb; k++) begin
      @(negedge clock);
      check("tx", tx, exp_bit(w, k));
      if (k == 0) begin
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", ready, 0);
        check("word_sent_early", word_sent, 0);
      end
      if (k == 40 * Cpb - 1) begin
        check("word_sent_before_end", word_sent, 0);
        check("ready_before_end", ready, 0);
      end
      case (mode)
        MDrop: valid = 1'b0;
        MScramble: begin
          if (k < 40 * Cpb - 1) begin
            data_in = $urandom;
            valid   = 1'($urandom_range(0, 1));
            last    = 1'($urandom_range(0, 1));
          end else begin
            valid = 1'b0;
            last  = 1'b0;
          end
        end
        default: ;
      endcase
    end
    @(negedge clock);
    check("word_sent", word_sent, 1);
    check("done", done, 32'(l));
    check("ready_at_end", ready, 1);
    check("busy_at_end", busy, 0);
    check("tx_idle_at_end", tx, 1);
  endtask

  initial begin
    int pulses;
    reset   = 1'b1;
    valid   = 1'b0;
    data_in = '0;
    last    = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_word_sent", word_sent, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single word, bit-exact frame check
    data_in = 32'hA5C3_0F81;
    last    = 1'b0;
    valid   = 1'b1;
    expect_word(32'hA5C3_0F81, 1'b0, MDrop);
    @(negedge clock);
    check("word_sent_one_cycle", word_sent, 0);

    // Back-to-back: second word accepted in the word_sent cycle
    data_in = 32'h1;
    valid   = 1'b1;
    expect_word(32'h1, 1'b0, MHold);
    check("gap_tx_high", tx, 1);
    data_in = 32'h2;
    expect_word(32'h2, 1'b0, MDrop);

    // Last word of image
    @(negedge clock);
    data_in = 32'hFFFF_FFFF;
    last    = 1'b1;
    valid   = 1'b1;
    expect_word(32'hFFFF_FFFF, 1'b1, MDrop);
    last = 1'b0;
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("word_sent_off", word_sent, 0);
    check("ready_after_last", ready, 1);

    // Reset during data bit 3 of byte 2
    data_in = 32'h1234_5678;
    valid   = 1'b1;
    for (int k = 0; k < 98; k++) begin
      @(negedge clock);
      valid = 1'b0;
    end
    check("pre_abort_tx", tx, 0);
    reset = 1'b1;
    @(negedge clock);
    check("abort_tx", tx, 1);
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_word_sent", word_sent, 0);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (word_sent) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    data_in = 32'h0000_00AA;
    valid   = 1'b1;
    expect_word(32'h0000_00AA, 1'b0, MDrop);

    // Inputs toggled while busy must not disturb the latched word
    @(negedge clock);
    data_in = 32'h3C5A_96E1;
    last    = 1'b0;
    valid   = 1'b1;
    expect_word(32'h3C5A_96E1, 1'b0, MScramble);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("post_busy", busy, 0);
      check("post_tx", tx, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
